// File: rtl/puf_ctrl_pkg.sv
// Shared types, default parameters and challenge helpers
// for the PUF ring-oscillator race controller.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RACE,
        SETTLE,
        DONE
    } state_t;

    localparam int DEF_N_BITS      = 16;
    localparam int DEF_SEL_W       = 4;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 65535;
    localparam int DEF_SETTLE_CYC  = 8;

    localparam int MAX_SEL_W = 8;
    localparam int CH_W      = 2 * MAX_SEL_W;

    // Pull base_a (upper) or base_b (lower) out of a packed challenge.
    function automatic logic [MAX_SEL_W-1:0] ch_field(
        input logic [CH_W-1:0] ch,
        input int              sel_w,
        input logic            upper
    );
        logic [CH_W-1:0]      sh;
        logic [MAX_SEL_W-1:0] mask;
        sh   = upper ? (ch >> sel_w) : ch;
        mask = MAX_SEL_W'((1 << sel_w) - 1);
        return sh[MAX_SEL_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/puf_race_controller_counter.sv
// Saturating edge counter for one oscillator of a race.
// fin latches high on the clock where count reaches target.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             pulse,
    input  logic [CNT_W-1:0] target,
    output logic             fin,
    output logic             hit
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nx;
    logic             step;

    // Next count, saturating at target; hit marks the reaching edge.
    always_comb begin
        step   = en && pulse && (count != target);
        cnt_nx = step ? count + CNT_W'(1) : count;
        hit    = step && (cnt_nx == target);
    end

    // Count register and sticky finished flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
            fin   <= 1'b0;
        end else begin
            count <= cnt_nx;
            if (hit) fin <= 1'b1;
        end
    end

endmodule

// File: rtl/puf_race_controller.sv
// Sequences ring-oscillator races bit by bit and assembles
// the PUF response from the external arbiter's verdicts.
module puf_race_controller
    import puf_ctrl_pkg::*;
#(
    parameter int N_BITS      = DEF_N_BITS,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*SEL_W-1:0] challenge,
    input  logic [CNT_W-1:0]   target_cnt,
    input  logic               ro_edge_a,
    input  logic               ro_edge_b,
    input  logic               arb_done,
    input  logic               arb_winner,
    output logic               ro_en,
    output logic [SEL_W-1:0]   ro_sel_a,
    output logic [SEL_W-1:0]   ro_sel_b,
    output logic               race_rst,
    output logic               fin_a,
    output logic               fin_b,
    output logic               busy,
    output logic [N_BITS-1:0]  response,
    output logic               resp_valid,
    output logic               err_timeout,
    output logic               tie_seen
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int ST_W  = $clog2(SETTLE_CYC + 1);

    state_t state, state_nx;

    logic [SEL_W-1:0] base_a, base_b;
    logic [SEL_W-1:0] sel_a_nx, sel_b_nx;
    logic [CNT_W-1:0] tgt;
    logic [IDX_W-1:0] bit_idx;
    logic [TO_W-1:0]  race_cyc;
    logic [ST_W-1:0]  settle_cnt;
    logic             same_pair, race_to, settle_end, last_bit;
    logic             hit_a, hit_b;

    assign sel_a_nx   = base_a + SEL_W'(bit_idx);
    assign sel_b_nx   = base_b + SEL_W'(bit_idx);
    assign same_pair  = (sel_a_nx == sel_b_nx);
    assign race_to    = (race_cyc == TO_W'(TIMEOUT_CYC - 1));
    assign settle_end = (settle_cnt == ST_W'(SETTLE_CYC - 1));
    assign last_bit   = (bit_idx == IDX_W'(N_BITS - 1));

    assign ro_en      = (state == RACE);
    assign race_rst   = (state inside {IDLE, SETUP, SETTLE});
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == SETUP),
        .en     (ro_en),
        .pulse  (ro_edge_a),
        .target (tgt),
        .fin    (fin_a),
        .hit    (hit_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == SETUP),
        .en     (ro_en),
        .pulse  (ro_edge_b),
        .target (tgt),
        .fin    (fin_b),
        .hit    (hit_b)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   state_nx = same_pair ? SETTLE : RACE;
            RACE:    if (arb_done || race_to) state_nx = SETTLE;
            SETTLE:  if (settle_end) state_nx = last_bit ? DONE : SETUP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Challenge latch, selects, cycle counters and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_a      <= '0;
            base_b      <= '0;
            tgt         <= CNT_W'(1);
            bit_idx     <= '0;
            ro_sel_a    <= '0;
            ro_sel_b    <= '0;
            race_cyc    <= '0;
            settle_cnt  <= '0;
            response    <= '0;
            err_timeout <= 1'b0;
            tie_seen    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_a <= SEL_W'(ch_field(CH_W'(challenge),
                                                  SEL_W, 1'b1));
                        base_b <= SEL_W'(ch_field(CH_W'(challenge),
                                                  SEL_W, 1'b0));
                        tgt    <= (target_cnt == '0) ? CNT_W'(1)
                                                     : target_cnt;
                        bit_idx     <= '0;
                        response    <= '0;
                        err_timeout <= 1'b0;
                        tie_seen    <= 1'b0;
                    end
                end
                SETUP: begin
                    ro_sel_a   <= sel_a_nx;
                    ro_sel_b   <= sel_b_nx;
                    race_cyc   <= '0;
                    settle_cnt <= '0;
                end
                RACE: begin
                    race_cyc <= race_cyc + TO_W'(1);
                    if (hit_a && hit_b) tie_seen <= 1'b1;
                    if (arb_done)     response[bit_idx] <= arb_winner;
                    else if (race_to) err_timeout <= 1'b1;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + ST_W'(1);
                    if (settle_end && !last_bit)
                        bit_idx <= bit_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_race_controller.sv
// Directed bench for puf_race_controller with a behavioural
// race arbiter (done on first fin, ties resolve to A).
module tb_puf_race_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  challenge;
    logic [15:0] target_cnt;
    logic        ro_edge_a, ro_edge_b;
    logic        arb_done, arb_winner;
    logic        ro_en, race_rst, fin_a, fin_b, busy;
    logic [3:0]  ro_sel_a, ro_sel_b;
    logic [3:0]  response;
    logic        resp_valid, err_timeout, tie_seen;

    logic        start2;
    logic [7:0]  challenge2;
    logic [15:0] target2;
    logic        no_edge = 1'b0;
    logic        arb_done2, arb_winner2;
    logic        ro_en2, race_rst2, fin_a2, fin_b2, busy2;
    logic [3:0]  ro_sel_a2, ro_sel_b2;
    logic [3:0]  response2;
    logic        resp_valid2, err_timeout2, tie_seen2;

    int n_run = 0;
    int n_fail = 0;
    int per_a = 0;
    int per_b = 0;

    always #5 clk = ~clk;

    assign arb_done    = fin_a | fin_b;
    assign arb_winner  = fin_a;
    assign arb_done2   = fin_a2 | fin_b2;
    assign arb_winner2 = fin_a2;

    puf_race_controller #(
        .N_BITS(4), .SEL_W(4), .CNT_W(16),
        .TIMEOUT_CYC(200), .SETTLE_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .challenge(challenge), .target_cnt(target_cnt),
        .ro_edge_a(ro_edge_a), .ro_edge_b(ro_edge_b),
        .arb_done(arb_done), .arb_winner(arb_winner),
        .ro_en(ro_en), .ro_sel_a(ro_sel_a), .ro_sel_b(ro_sel_b),
        .race_rst(race_rst), .fin_a(fin_a), .fin_b(fin_b),
        .busy(busy), .response(response),
        .resp_valid(resp_valid), .err_timeout(err_timeout),
        .tie_seen(tie_seen)
    );

    puf_race_controller #(
        .N_BITS(4), .SEL_W(4), .CNT_W(16),
        .TIMEOUT_CYC(20), .SETTLE_CYC(8)
    ) dut_to (
        .clk(clk), .rst(rst), .start(start2),
        .challenge(challenge2), .target_cnt(target2),
        .ro_edge_a(no_edge), .ro_edge_b(no_edge),
        .arb_done(arb_done2), .arb_winner(arb_winner2),
        .ro_en(ro_en2), .ro_sel_a(ro_sel_a2), .ro_sel_b(ro_sel_b2),
        .race_rst(race_rst2), .fin_a(fin_a2), .fin_b(fin_b2),
        .busy(busy2), .response(response2),
        .resp_valid(resp_valid2), .err_timeout(err_timeout2),
        .tie_seen(tie_seen2)
    );

    // Periodic oscillator edge pulses; period 0 means silent.
    initial begin
        int ph_a, ph_b;
        ph_a = 0;
        ph_b = 0;
        ro_edge_a = 1'b0;
        ro_edge_b = 1'b0;
        forever begin
            @(negedge clk);
            ph_a++;
            ph_b++;
            ro_edge_a = (per_a != 0) && ((ph_a % per_a) == 0);
            ro_edge_b = (per_b != 0) && ((ph_b % per_b) == 0);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic launch(input logic [7:0] ch, input logic [15:0] tg);
        @(negedge clk);
        challenge  = ch;
        target_cnt = tg;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_en(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (ro_en === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(output int k, output int en_cnt,
                              output bit ok);
        k = 2;
        en_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (ro_en === 1'b1) en_cnt++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        challenge = '0;
        target_cnt = '0;
        start2 = 1'b0;
        challenge2 = '0;
        target2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ro_en", ro_en, 0);
        chk("rst_race_rst", race_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_response", response, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_sel", {ro_sel_a, ro_sel_b}, 0);
        chk("rst_flags", {err_timeout, tie_seen, fin_a, fin_b}, 0);
    endtask

    task automatic run_race(input string nm, input int pa[4],
                            input int pb[4], input logic [3:0] exp);
        bit ok;
        int k, en;
        per_a = pa[0];
        per_b = pb[0];
        launch(8'h15, 16'd10);
        for (int b = 0; b < 4; b++) begin
            wait_en(1'b1, ok);
            chk({nm, "_en_rise"}, ok, 1);
            chk({nm, "_sel_a"}, ro_sel_a, (1 + b) % 16);
            chk({nm, "_sel_b"}, ro_sel_b, (5 + b) % 16);
            wait_en(1'b0, ok);
            chk({nm, "_en_fall"}, ok, 1);
            if (b < 3) begin
                per_a = pa[b + 1];
                per_b = pb[b + 1];
            end
        end
        wait_valid(k, en, ok);
        chk({nm, "_valid"}, ok, 1);
        chk({nm, "_response"}, response, exp);
        chk({nm, "_timeout"}, err_timeout, 0);
        @(negedge clk);
        chk({nm, "_valid_pulse"}, resp_valid, 0);
        chk({nm, "_busy_done"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({nm, "_held"}, response, exp);
    endtask

    task automatic test_basic();
        run_race("basic", '{2, 2, 2, 2}, '{3, 3, 3, 3}, 4'b1111);
    endtask

    task automatic test_mixed();
        run_race("mixed", '{2, 3, 2, 3}, '{3, 2, 3, 2}, 4'b0101);
    endtask

    task automatic test_same_pair();
        bit ok;
        int k, en;
        per_a = 2;
        per_b = 3;
        launch(8'h33, 16'd10);
        wait_valid(k, en, ok);
        chk("same_valid", ok, 1);
        chk("same_latency", k, 38);
        chk("same_en_cycles", en, 0);
        chk("same_response", response, 0);
    endtask

    task automatic test_tie();
        bit ok;
        int k, en;
        per_a = 1;
        per_b = 1;
        repeat (2) @(negedge clk);
        launch(8'h15, 16'd5);
        wait_valid(k, en, ok);
        chk("tie_valid", ok, 1);
        chk("tie_latency", k, 62);
        chk("tie_en_cycles", en, 24);
        chk("tie_response", response, 4'b1111);
        chk("tie_seen", tie_seen, 1);
        chk("tie_timeout", err_timeout, 0);
    endtask

    task automatic test_timeout();
        int k, en;
        bit ok;
        @(negedge clk);
        challenge2 = 8'h01;
        target2 = 16'd10;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 2;
        en = 0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (resp_valid2 === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (ro_en2 === 1'b1) en++;
            @(negedge clk);
            k++;
        end
        chk("to_valid", ok, 1);
        chk("to_latency", k, 118);
        chk("to_en_cycles", en, 80);
        chk("to_response", response2, 0);
        chk("to_err", err_timeout2, 1);
    endtask

    task automatic test_rst_mid_race();
        bit ok;
        int k, en;
        per_a = 2;
        per_b = 3;
        launch(8'h15, 16'd10);
        wait_en(1'b1, ok);
        chk("mid_bit0_en", ok, 1);
        chk("mid_tie_cleared", tie_seen, 0);
        @(negedge clk);
        challenge = 8'h77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_busy", busy, 1);
        wait_en(1'b0, ok);
        wait_en(1'b1, ok);
        chk("mid_bit1_en", ok, 1);
        chk("mid_nolatch", {ro_sel_a, ro_sel_b}, 8'h26);
        wait_en(1'b0, ok);
        wait_en(1'b1, ok);
        chk("mid_bit2_en", ok, 1);
        chk("mid_partial", response, 4'b0011);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_ro_en", ro_en, 0);
        chk("mid_busy_rst", busy, 0);
        chk("mid_response", response, 0);
        chk("mid_race_rst", race_rst, 1);
        chk("mid_sel", {ro_sel_a, ro_sel_b}, 0);
        launch(8'h15, 16'd10);
        wait_valid(k, en, ok);
        chk("rerun_valid", ok, 1);
        chk("rerun_response", response, 4'b1111);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed();
        test_same_pair();
        test_tie();
        test_timeout();
        test_rst_mid_race();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_race_controller.md
Name: puf_race_controller

Overview:
Sequences ring-oscillator races to build an N_BITS PUF response. For each bit it:
- selects an RO pair from the latched challenge,
- clears the race logic and enables the oscillators,
- counts synchronized edge pulses per RO and raises finished flags into the external combinational race arbiter,
- samples the arbiter's done/winner and shifts the result into the response register.

It sits between the host/UART command logic and the RO bank plus race arbiter.

Parameters:
N_BITS, 16, response bits produced per start
SEL_W, 4, RO select width (2^SEL_W oscillators)
CNT_W, 16, edge counter width
TIMEOUT_CYC, 65535, max RACE cycles before a bit is abandoned
SETTLE_CYC, 8, cycles with ro_en low between races

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  pulse; begin a response; ignored while busy
challenge  in  2*SEL_W  {base_a, base_b}, latched on accepted start
target_cnt  in  CNT_W  edges required to finish, latched on start; 0 treated as 1
ro_edge_a  in  1  one-cycle pulse per rising edge of RO A (already synchronized)
ro_edge_b  in  1  one-cycle pulse per rising edge of RO B
arb_done  in  1  race arbiter done
arb_winner  in  1  race arbiter winner (1 = A first)
ro_en  out  1  enables selected oscillators
ro_sel_a  out  SEL_W  RO A select
ro_sel_b  out  SEL_W  RO B select
race_rst  out  1  clears arbiter; high in IDLE, SETUP, SETTLE
fin_a  out  1  to arbiter finished1
fin_b  out  1  to arbiter finished2
busy  out  1  high in all states except IDLE
response  out  N_BITS  assembled response, held until next accepted start
resp_valid  out  1  one-cycle pulse when response complete
err_timeout  out  1  sticky; set if any bit timed out; cleared on accepted start
tie_seen  out  1  sticky; set if fin_a and fin_b rose in the same cycle; cleared on start

Behaviour:
- Reset values: ro_en=0, ro_sel_a/b=0, race_rst=1, fin_a/b=0, busy=0, response=0, resp_valid=0, err_timeout=0, tie_seen=0; state IDLE; bit_idx=0.
- States: IDLE -> SETUP -> RACE -> SETTLE -> (SETUP | DONE) -> IDLE.
- IDLE: on start=1, latch challenge and target_cnt, clear response and sticky flags, bit_idx=0, go to SETUP next cycle.
- SETUP (1 cycle):
  - ro_sel_a = base_a + bit_idx, ro_sel_b = base_b + bit_idx, both mod 2^SEL_W.
  - Edge counters cleared; race_rst=1.
  - If ro_sel_a == ro_sel_b: bit = 0, RACE skipped, go to SETTLE.
- RACE:
  - ro_en=1, race_rst=0.
  - Each edge pulse increments its counter; counters saturate at target.
  - fin_x = (cnt_x == target), registered; fin_x stays high once reached.
  - On the first cycle arb_done=1: response[bit_idx] = arb_winner, go to SETTLE.
  - If fin_a and fin_b first assert in the same cycle, set tie_seen; the arbiter resolves the tie to A (winner=1), and that value is recorded.
  - If TIMEOUT_CYC RACE cycles elapse without arb_done: bit = 0, set err_timeout, go to SETTLE.
- SETTLE: ro_en=0, race_rst=1 for SETTLE_CYC cycles. Then:
  - if bit_idx == N_BITS-1, go to DONE;
  - else bit_idx++ and go to SETUP.
- DONE (1 cycle): resp_valid=1, busy still 1; next cycle IDLE.
- Latency per bit = 1 + race_cycles + SETTLE_CYC, where race_cycles runs from RACE entry to the first cycle arb_done=1. The fin register adds 1 cycle after the target edge, so race_cycles = (cycles to target edge) + 1.
  - With fin registered at the target-edge clock, arb_done is seen the following cycle.
  - Total = sum over bits + 1 (DONE) + 1 (IDLE->SETUP).
- Edge pulses outside RACE are ignored.
- start during busy is ignored; the challenge is not re-latched.
- rst mid-race: takes effect at the next clk edge, returns all outputs to reset values (ro_en drops), and discards the partial response.

Decomposition:
- Shared package puf_ctrl_pkg: state enum (IDLE, SETUP, RACE, SETTLE, DONE), default parameter constants, and the challenge field slicing helper.
- One sub-module, ro_edge_counter (clear, en, edge, target -> saturating count, fin), instantiated twice.

Test Plan:
1. N_BITS=4, challenge {0x1,0x5}, target=10; A edges every 2 cycles, B every 3 -> response=4'b1111, resp_valid one pulse, selects 1/5, 2/6, 3/7, 4/8.
2. Same setup with B faster on bits 1 and 3 only -> response=4'b0101 (bit0 LSB=1), err_timeout=0.
3. challenge {0x3,0x3} -> every pair is identical, no RACE entered, ro_en never high, response=0.
4. Edges on A and B in the same cycle reaching target=5 -> winner 1 recorded, tie_seen=1.
5. No edges, TIMEOUT_CYC=20 -> each bit leaves RACE after 20 cycles, err_timeout=1, response=0.
6. rst asserted during RACE of bit 2 -> next cycle ro_en=0, busy=0, response=0; a later start rerun completes normally; start pulsed while busy is ignored.
